// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit and its one-bit step stage.
//   - SHIFT_WIDTH : default operand/result width
//   - op_t        : shift op encodings (2'b11 is reserved and behaves as SLL)
//   - state_t     : sequencer states
package shift_pkg;

    localparam int SHIFT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step1.sv
// One-bit combinational shift stage.
//   op   : 2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 treated as SLL
//   din  : operand
//   dout : din shifted by exactly one position
// Built bit-by-bit so it can be replicated as one rank of a barrel shifter.
module shift_step1
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic shift_right;
    logic fill_bit;

    assign shift_right = (op == OP_SRL) || (op == OP_SRA);
    // Arithmetic right shift replicates the sign bit into the vacated MSB.
    assign fill_bit    = (op == OP_SRA) ? din[WIDTH-1] : 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign dout[gi] = shift_right ? din[gi+1] : 1'b0;
            end else if (gi == WIDTH - 1) begin : g_msb
                assign dout[gi] = shift_right ? fill_bit : din[gi-1];
            end else begin : g_mid
                assign dout[gi] = shift_right ? din[gi+1] : din[gi-1];
            end
        end
    endgenerate

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative multi-cycle shifter: one bit position per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request, only honoured in IDLE
//   op    : shift op (SLL/SRL/SRA, 2'b11 = SLL), sampled with start
//   src   : operand, sampled with start
//   shamt : unsigned shift amount, sampled with start
//   busy  : high whenever not IDLE
//   done  : one-cycle pulse, dout valid
//   dout  : accumulator; holds the last result until the next accept
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   cnt_reg;
    logic [1:0]       op_reg;
    logic             busy_reg;
    logic             done_reg;

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .op   (op_reg),
        .din  (acc_reg),
        .dout (acc_next)
    );

    // busy/done are registered alongside the state so they always equal
    // a decode of state_reg without any path from the inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            op_reg    <= OP_SLL;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        acc_reg  <= src;
                        cnt_reg  <= shamt;
                        op_reg   <= op;
                        busy_reg <= 1'b1;
                        // A zero shift skips straight to the result cycle.
                        if (shamt == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - SHW'(1);
                    if (cnt_reg == SHW'(1)) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // start is ignored here; the earliest re-accept is next cycle.
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign dout = acc_reg;

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op    = 2'b00;
    logic [WIDTH-1:0] src   = '0;
    logic [SHW-1:0]   shamt = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    int vectors     = 0;
    int miscompares = 0;

    shift_seq_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src   (src),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // Reference: the whole shift in one go with the language operators.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] o,
                                                   input logic [WIDTH-1:0] s,
                                                   input int n);
        logic signed [WIDTH-1:0] ss;
        ss = s;
        case (o)
            2'b01:   return s >> n;
            2'b10:   return WIDTH'(ss >>> n);
            default: return s << n;
        endcase
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // Present one request, accept it, then wait (bounded) for done.
    // Checks busy during the run, the latency and the result.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] s,
                         input logic [SHW-1:0] n, input bit keep_start);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; src = s; shamt = n;
        @(posedge clk);
        #1;
        if (!keep_start) begin
            start = 1'b0;
            op    = 2'($urandom);
            src   = $urandom;
            shamt = SHW'($urandom);
        end
        lat = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j;
                break;
            end
            if (busy !== 1'b1) check("busy_in_flight", WIDTH'(busy), WIDTH'(1));
        end
        check("latency", WIDTH'(lat), WIDTH'(n) + 1);
        check("result", dout, ref_shift(o, s, int'(n)));
        check("busy_at_done", WIDTH'(busy), WIDTH'(1));
    endtask

    initial begin
        int pulses;
        logic [WIDTH-1:0] last;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", WIDTH'(busy), '0);
        check("reset_done", WIDTH'(done), '0);
        check("reset_dout", dout, '0);
        rst_n = 1'b1;

        // Reset mid-operation: nothing in flight survives
        @(negedge clk);
        start = 1'b1; op = 2'b00; src = 32'h0000_0001; shamt = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", WIDTH'(busy), '0);
        check("midrst_done", WIDTH'(done), '0);
        check("midrst_dout", dout, '0);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", WIDTH'(pulses), '0);

        // Directed corners
        issue(2'b10, 32'hDEAD_BEEF, 5'd0, 1'b0);
        check("zero_shift_value", dout, 32'hDEAD_BEEF);
        issue(2'b00, 32'hFFFF_FFFF, 5'd31, 1'b0);
        check("max_shift_value", dout, 32'h8000_0000);
        issue(2'b10, 32'h8000_0010, 5'd4, 1'b0);
        check("sra_value", dout, 32'hF800_0001);
        issue(2'b01, 32'h8000_0010, 5'd4, 1'b0);
        check("srl_value", dout, 32'h0800_0001);
        issue(2'b11, 32'h8000_0010, 5'd4, 1'b0);
        check("reserved_as_sll", dout, 32'h0000_0100);

        // start held through DONE: ignored there, accepted the cycle after
        issue(2'b00, 32'h0000_0001, 5'd3, 1'b1);
        check("hold_start_value", dout, 32'h0000_0008);
        @(negedge clk);
        check("gap_busy", WIDTH'(busy), '0);
        check("gap_done", WIDTH'(done), '0);
        @(negedge clk);
        check("reaccept_busy", WIDTH'(busy), WIDTH'(1));
        start  = 1'b0;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            if (done) begin
                pulses = 1;
                break;
            end
            @(negedge clk);
        end
        check("reaccept_done_seen", WIDTH'(pulses), WIDTH'(1));
        check("reaccept_value", dout, 32'h0000_0008);

        // Hold: inputs wiggle with start low, result stays
        last = dout;
        repeat (10) begin
            @(posedge clk);
            #1;
            src   = $urandom;
            shamt = SHW'($urandom);
            op    = 2'($urandom);
            @(negedge clk);
            check("hold_dout", dout, last);
            check("hold_busy", WIDTH'(busy), '0);
        end

        // Randomized operations against the reference
        repeat (40) begin
            issue(2'($urandom_range(0, 3)), $urandom, SHW'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
